// File: rtl/nx_riscv_pkg.sv
// Shared encodings for the nx_riscv core: opcodes, funct fields, ALU operations.
package nx_riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASS_B
    } alu_op_e;

    typedef struct packed {
        logic    valid;
        alu_op_e op;
    } alu_sel_t;

    // Map funct3/funct7 of an OP or OP-IMM instruction to an ALU operation.
    // For OP-IMM, f7 is imm[11:5], which only matters for the shift forms.
    function automatic alu_sel_t alu_decode(input logic [2:0] f3, input logic [6:0] f7,
                                            input logic is_reg);
        alu_sel_t s;
        logic     base_ok;
        base_ok = !is_reg || (f7 == F7_BASE);
        s.valid = base_ok;
        s.op    = ALU_ADD;
        case (f3)
            F3_ADD: begin
                s.op    = (is_reg && f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                s.valid = base_ok || (f7 == F7_ALT);
            end
            F3_SLL: begin
                s.op    = ALU_SLL;
                s.valid = (f7 == F7_BASE);
            end
            F3_SLT:  s.op = ALU_SLT;
            F3_SLTU: s.op = ALU_SLTU;
            F3_XOR:  s.op = ALU_XOR;
            F3_SR: begin
                s.op    = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                s.valid = (f7 == F7_BASE) || (f7 == F7_ALT);
            end
            F3_OR:   s.op = ALU_OR;
            default: s.op = ALU_AND;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/nx_riscv_alu.sv
// 32-bit integer ALU for the nx_riscv core; zero flag drives BEQ/BNE.
module nx_riscv_alu
    import nx_riscv_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] result,
    output logic        zero
);

    // Operation select; shifts use only the low five bits of b.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        result = '0;
        case (op)
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_AND:    result = a & b;
            ALU_OR:     result = a | b;
            ALU_XOR:    result = a ^ b;
            ALU_SLL:    result = a << b[4:0];
            ALU_SRL:    result = a >> b[4:0];
            ALU_SRA:    result = $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:    result = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU:   result = {31'd0, a < b};
            ALU_PASS_B: result = b;
            default:    result = '0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/nx_riscv_top.sv
// Single-cycle RV32I-subset core with instruction RAM, data RAM and register
// file, plus side-band load ports that preload storage independent of reset.
module nx_riscv_top
    import nx_riscv_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_ram_wen,
    input  logic [31:0] inst_ram_waddr,
    input  logic [31:0] inst_ram_wdata,
    input  logic        data_ram_wen_initial,
    input  logic [31:0] data_ram_waddr_initial,
    input  logic [31:0] data_ram_wdata_initial,
    input  logic        regfile_wen_initial,
    input  logic [4:0]  regfile_waddr_initial,
    input  logic [31:0] regfile_wdata_initial
);

    localparam int IA_W = $clog2(IMEM_WORDS);
    localparam int DA_W = $clog2(DMEM_WORDS);

    logic [31:0] imem_q  [IMEM_WORDS];
    logic [31:0] dmem_q  [DMEM_WORDS];
    logic [31:0] rf_q    [32];
    logic [31:0] regfile [32];

    logic [31:0] pc_q, pc_d, pc, pc_plus4;
    logic [31:0] instr;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    alu_sel_t    alu_sel;
    alu_op_e     alu_op;
    logic [31:0] alu_b, alu_result, wb_data;
    logic        alu_zero, rd_we, dm_we, core_rf_we, core_dm_we;
    logic [DA_W-1:0] dm_idx;
    logic        unused_addr_bits;

    assign pc       = pc_q;
    assign pc_plus4 = pc + 32'd4;
    assign instr    = imem_q[pc[IA_W+1:2]];

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};

    // Architectural register view: x0 reads zero whatever its storage holds.
    always_comb begin
        regfile[0] = '0;
        for (int i = 1; i < 32; i++) regfile[i] = rf_q[i];
    end

    assign rs1_val = regfile[rs1];
    assign rs2_val = regfile[rs2];

    // ALU operand and operation select per instruction class.
    always_comb begin
        alu_sel = alu_decode(funct3, funct7, opcode == OPC_OP);
        alu_op  = alu_sel.op;
        alu_b   = rs2_val;
        case (opcode)
            OPC_OP_IMM: alu_b = imm_i;
            OPC_LOAD:   begin alu_op = ALU_ADD;    alu_b = imm_i; end
            OPC_STORE:  begin alu_op = ALU_ADD;    alu_b = imm_s; end
            OPC_BRANCH: alu_op = ALU_SUB;
            OPC_LUI:    begin alu_op = ALU_PASS_B; alu_b = imm_u; end
            default: ;
        endcase
    end

    nx_riscv_alu u_alu (
        .a      (rs1_val),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    assign dm_idx = alu_result[DA_W+1:2];

    // Write-back, store enable and next-pc selection; unknown encodings fall through as no-ops.
    always_comb begin
        rd_we   = 1'b0;
        dm_we   = 1'b0;
        wb_data = alu_result;
        pc_d    = pc_plus4;
        case (opcode)
            OPC_OP, OPC_OP_IMM: rd_we = alu_sel.valid;
            OPC_LOAD: if (funct3 == F3_LW) begin
                rd_we   = 1'b1;
                wb_data = dmem_q[dm_idx];
            end
            OPC_STORE: dm_we = (funct3 == F3_SW);
            OPC_BRANCH:
                if ((funct3 == F3_BEQ && alu_zero) || (funct3 == F3_BNE && !alu_zero))
                    pc_d = pc + imm_b;
            OPC_JAL: begin
                rd_we   = 1'b1;
                wb_data = pc_plus4;
                pc_d    = pc + imm_j;
            end
            OPC_LUI: rd_we = 1'b1;
            default: ;
        endcase
    end

    // Nothing retires while reset is held low.
    assign core_rf_we = rst_n && rd_we;
    assign core_dm_we = rst_n && dm_we;

    // Program counter: forced to zero asynchronously while reset is low.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!rst_n) pc_q <= 32'd0;
        else        pc_q <= pc_d;
    end

    // Instruction RAM: written only through its load port.
    always_ff @(posedge clk) begin
        // NOTE: the RAMs and register file have no reset so their contents survive reset pulses.
        if (inst_ram_wen) imem_q[inst_ram_waddr[IA_W+1:2]] <= inst_ram_wdata;
    end

    // Data RAM: core store first, load port last so it wins on a collision.
    always_ff @(posedge clk) begin
        if (core_dm_we) dmem_q[dm_idx] <= rs2_val;
        if (data_ram_wen_initial)
            dmem_q[data_ram_waddr_initial[DA_W+1:2]] <= data_ram_wdata_initial;
    end

    // Register file: core write-back first, load port last so it wins; x0 storage is masked on read.
    always_ff @(posedge clk) begin
        if (core_rf_we) rf_q[rd] <= wb_data;
        if (regfile_wen_initial) rf_q[regfile_waddr_initial] <= regfile_wdata_initial;
    end

    assign unused_addr_bits = ^{inst_ram_waddr[31:IA_W+2], inst_ram_waddr[1:0],
                                data_ram_waddr_initial[31:DA_W+2], data_ram_waddr_initial[1:0]};

endmodule

// File: tb/tb_nx_riscv_top.sv
// Self-checking bench for nx_riscv_top: single-instruction vector table plus
// hand-written multi-cycle sequences (loads, stores, branches, reset).
module tb_nx_riscv_top;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_ram_wen = 1'b0;
    logic [31:0] inst_ram_waddr = '0;
    logic [31:0] inst_ram_wdata = '0;
    logic        data_ram_wen_initial = 1'b0;
    logic [31:0] data_ram_waddr_initial = '0;
    logic [31:0] data_ram_wdata_initial = '0;
    logic        regfile_wen_initial = 1'b0;
    logic [4:0]  regfile_waddr_initial = '0;
    logic [31:0] regfile_wdata_initial = '0;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] KEEP = 32'hA5A5_A5A5;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_x3;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    nx_riscv_top #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .inst_ram_wen           (inst_ram_wen),
        .inst_ram_waddr         (inst_ram_waddr),
        .inst_ram_wdata         (inst_ram_wdata),
        .data_ram_wen_initial   (data_ram_wen_initial),
        .data_ram_waddr_initial (data_ram_waddr_initial),
        .data_ram_wdata_initial (data_ram_wdata_initial),
        .regfile_wen_initial    (regfile_wen_initial),
        .regfile_waddr_initial  (regfile_waddr_initial),
        .regfile_wdata_initial  (regfile_wdata_initial)
    );

    always #5 clk = ~clk;

    // R-type with rd=x3, rs1=x1, rs2=x2.
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    // OP-IMM with rd=x3, rs1=x1.
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3);
        return {imm, 5'd1, f3, 5'd3, 7'b0010011};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // Each load task starts at a falling edge and spends exactly one rising edge.
    task automatic load_imem(input logic [31:0] addr, input logic [31:0] data);
        inst_ram_wen = 1'b1; inst_ram_waddr = addr; inst_ram_wdata = data;
        @(negedge clk);
        inst_ram_wen = 1'b0;
    endtask

    task automatic load_dmem(input logic [31:0] addr, input logic [31:0] data);
        data_ram_wen_initial = 1'b1; data_ram_waddr_initial = addr; data_ram_wdata_initial = data;
        @(negedge clk);
        data_ram_wen_initial = 1'b0;
    endtask

    task automatic load_reg(input logic [4:0] idx, input logic [31:0] data);
        regfile_wen_initial = 1'b1; regfile_waddr_initial = idx; regfile_wdata_initial = data;
        @(negedge clk);
        regfile_wen_initial = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        rst_n = 1'b0;
        load_imem(32'h0, v.instr);
        load_reg(5'd1, v.a);
        load_reg(5'd2, v.b);
        load_reg(5'd3, KEEP);
        rst_n = 1'b1;
        @(negedge clk);
        check($sformatf("%s x3", v.name), dut.regfile[3], v.exp_x3);
        check($sformatf("%s pc", v.name), dut.pc, v.exp_pc);
    endtask

    initial begin
        vecs.push_back('{"add",    enc_r(7'h00, 3'd0), 32'd38,        32'd22,        32'd60,        32'h4});
        vecs.push_back('{"add_wrap", enc_r(7'h00, 3'd0), 32'hFFFF_FFFF, 32'd2,       32'd1,         32'h4});
        vecs.push_back('{"sub",    enc_r(7'h20, 3'd0), 32'd5,         32'd7,         32'hFFFF_FFFE, 32'h4});
        vecs.push_back('{"and",    enc_r(7'h00, 3'd7), 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 32'h4});
        vecs.push_back('{"or",     enc_r(7'h00, 3'd6), 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 32'h4});
        vecs.push_back('{"xor",    enc_r(7'h00, 3'd4), 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 32'h4});
        vecs.push_back('{"sll",    enc_r(7'h00, 3'd1), 32'd1,         32'h23,        32'd8,         32'h4});
        vecs.push_back('{"srl",    enc_r(7'h00, 3'd5), 32'h8000_0000, 32'd4,         32'h0800_0000, 32'h4});
        vecs.push_back('{"sra",    enc_r(7'h20, 3'd5), 32'h8000_0000, 32'd4,         32'hF800_0000, 32'h4});
        vecs.push_back('{"slt",    enc_r(7'h00, 3'd2), 32'hFFFF_FFFF, 32'd1,         32'd1,         32'h4});
        vecs.push_back('{"sltu",   enc_r(7'h00, 3'd3), 32'hFFFF_FFFF, 32'd1,         32'd0,         32'h4});
        vecs.push_back('{"addi",   enc_i(12'hFFF, 3'd0), 32'd0,       32'd0,         32'hFFFF_FFFF, 32'h4});
        vecs.push_back('{"slti",   enc_i(12'hFFF, 3'd2), 32'hFFFF_FFFE, 32'd0,       32'd1,         32'h4});
        vecs.push_back('{"sltiu",  enc_i(12'hFFF, 3'd3), 32'd5,       32'd0,         32'd1,         32'h4});
        vecs.push_back('{"andi",   enc_i(12'h0F0, 3'd7), 32'hFF,      32'd0,         32'hF0,        32'h4});
        vecs.push_back('{"ori",    enc_i(12'h100, 3'd6), 32'h0F,      32'd0,         32'h10F,       32'h4});
        vecs.push_back('{"xori",   enc_i(12'hFFF, 3'd4), 32'h0F0F_0F0F, 32'd0,       32'hF0F0_F0F0, 32'h4});
        vecs.push_back('{"slli",   enc_i(12'h01F, 3'd1), 32'd1,       32'd0,         32'h8000_0000, 32'h4});
        vecs.push_back('{"srli",   enc_i(12'h01F, 3'd5), 32'h8000_0000, 32'd0,       32'd1,         32'h4});
        vecs.push_back('{"srai",   enc_i(12'h41F, 3'd5), 32'h8000_0000, 32'd0,       32'hFFFF_FFFF, 32'h4});
        vecs.push_back('{"lui",    {20'h12345, 5'd3, 7'b0110111}, 32'd0, 32'd0,     32'h1234_5000, 32'h4});
        vecs.push_back('{"beq_t",  32'h0020_8463, 32'd3, 32'd3,                      KEEP,          32'h8});
        vecs.push_back('{"beq_n",  32'h0020_8463, 32'd3, 32'd4,                      KEEP,          32'h4});
        vecs.push_back('{"bne_n",  32'h0020_9463, 32'd3, 32'd3,                      KEEP,          32'h4});
        vecs.push_back('{"bne_t",  32'h0020_9463, 32'd3, 32'd4,                      KEEP,          32'h8});
        vecs.push_back('{"jal",    32'h00C0_01EF, 32'd0, 32'd0,                      32'h4,         32'hC});
        vecs.push_back('{"bad_f7", enc_r(7'h01, 3'd0), 32'd1,         32'd2,         KEEP,          32'h4});
        vecs.push_back('{"bad_and", enc_r(7'h20, 3'd7), 32'hFF,       32'hFF,        KEEP,          32'h4});
        vecs.push_back('{"bad_slli", enc_i(12'h401, 3'd1), 32'd1,     32'd0,         KEEP,          32'h4});
        vecs.push_back('{"zero_word", 32'h0, 32'd1, 32'd2,                            KEEP,          32'h4});
        vecs.push_back('{"lb_nop", {12'd0, 5'd1, 3'd0, 5'd3, 7'b0000011}, 32'd0, 32'd0, KEEP,      32'h4});

        // Reset state before any clock edge.
        #1;
        check("reset pc", dut.pc, 32'h0);
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // add x3,x2,x1 at 0x08 behind two zero words.
        rst_n = 1'b0;
        load_imem(32'h0, 32'h0);
        load_imem(32'h4, 32'h0);
        load_imem(32'h8, 32'h0011_01B3);
        load_reg(5'd1, 32'd38);
        load_reg(5'd2, 32'd22);
        load_reg(5'd3, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("seq_add pc1", dut.pc, 32'h4);
        check("seq_add x3 after nop", dut.regfile[3], 32'd0);
        @(negedge clk);
        check("seq_add pc2", dut.pc, 32'h8);
        check("seq_add x1 after nop", dut.regfile[1], 32'd38);
        @(negedge clk);
        check("seq_add x3", dut.regfile[3], 32'd60);
        check("seq_add pc3", dut.pc, 32'hC);
        check("seq_add x1", dut.regfile[1], 32'd38);
        check("seq_add x2", dut.regfile[2], 32'd22);

        // Load-port write beats a core write to the same register; x0 ignores load port.
        rst_n = 1'b0;
        load_imem(32'h0, 32'h0070_0093);
        load_reg(5'd1, 32'd5);
        rst_n = 1'b1;
        load_reg(5'd1, 32'd9);
        check("collide x1", dut.regfile[1], 32'd9);
        check("collide pc", dut.pc, 32'h4);
        load_reg(5'd0, 32'hFFFF_FFFF);
        check("x0 load", dut.regfile[0], 32'h0);

        // lw x5,16(x0); sw x5,20(x0).
        rst_n = 1'b0;
        load_dmem(32'h10, 32'hDEAD_BEEF);
        load_dmem(32'h14, 32'h0);
        load_reg(5'd5, 32'h0);
        load_imem(32'h0, 32'h0100_2283);
        load_imem(32'h4, 32'h0050_2A23);
        rst_n = 1'b1;
        @(negedge clk);
        check("lw x5", dut.regfile[5], 32'hDEAD_BEEF);
        @(negedge clk);
        check("sw word 0x14", dut.dmem_q[5], 32'hDEAD_BEEF);
        check("lw src word 0x10", dut.dmem_q[4], 32'hDEAD_BEEF);

        // beq taken to 0x08, then jal x1,-4 back to 0x04.
        rst_n = 1'b0;
        load_reg(5'd1, 32'd3);
        load_reg(5'd2, 32'd3);
        load_imem(32'h0, 32'h0020_8463);
        load_imem(32'h8, 32'hFFDF_F0EF);
        rst_n = 1'b1;
        @(negedge clk);
        check("br_jal pc after beq", dut.pc, 32'h8);
        @(negedge clk);
        check("br_jal pc after jal", dut.pc, 32'h4);
        check("br_jal x1 link", dut.regfile[1], 32'hC);

        // Reset asserted mid-program: pc clears immediately, registers retained.
        rst_n = 1'b0;
        load_reg(5'd1, 32'd0);
        load_imem(32'h0, 32'h0010_8093);
        load_imem(32'h4, 32'h0010_8093);
        load_imem(32'h8, 32'h0010_8093);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst pc before", dut.pc, 32'hC);
        check("midrst x1 before", dut.regfile[1], 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("midrst pc async", dut.pc, 32'h0);
        repeat (2) @(negedge clk);
        check("midrst pc held", dut.pc, 32'h0);
        check("midrst x1 kept", dut.regfile[1], 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nx_riscv_top.md
NX_RISCV_TOP -- requirements
Module: nx_riscv_top

Interface
REQ-001 Parameter IMEM_WORDS, 256, instruction RAM depth in 32-bit words.
REQ-002 Parameter DMEM_WORDS, 256, data RAM depth in 32-bit words.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 inst_ram_wen  input  1  instruction RAM load strobe.
REQ-006 inst_ram_waddr  input  32  instruction RAM load byte address.
REQ-007 inst_ram_wdata  input  32  instruction RAM load data.
REQ-008 data_ram_wen_initial  input  1  data RAM load strobe.
REQ-009 data_ram_waddr_initial  input  32  data RAM load byte address.
REQ-010 data_ram_wdata_initial  input  32  data RAM load data.
REQ-011 regfile_wen_initial  input  1  register file load strobe.
REQ-012 regfile_waddr_initial  input  5  register file load index.
REQ-013 regfile_wdata_initial  input  32  register file load data.
REQ-014 The block SHALL have no output ports; pc (32 bits) and regfile (32x32 array) SHALL be exposed as internal signals with exactly these names for hierarchical probing.

Function
REQ-015 The core SHALL be a single-cycle RV32I subset: each rising edge out of reset retires one instruction and updates pc.
REQ-016 Instruction fetch SHALL be a combinational read of instruction RAM word pc[log2(IMEM_WORDS)+1:2]; upper address bits ignored (wrap).
REQ-017 Supported: R-type ADD SUB AND OR XOR SLL SRL SRA SLT SLTU; I-type ADDI ANDI ORI XORI SLTI SLTIU SLLI SRLI SRAI; LW; SW; BEQ BNE; JAL; LUI.
REQ-018 Any other encoding (including 0x00000000) SHALL act as a no-op: no register/memory write, pc <= pc+4.
REQ-019 Default next pc SHALL be pc+4; taken branch and JAL SHALL use pc+sign-extended immediate; JAL writes pc+4 to rd.
REQ-020 Arithmetic SHALL be 32-bit modulo 2^32; shifts use amount [4:0]; SLT signed, SLTU unsigned.
REQ-021 Register reads SHALL be combinational; x0 SHALL always read 0 and ignore every write, including load-port writes.
REQ-022 Register write-back SHALL occur on the rising edge ending the instruction's cycle.
REQ-023 LW SHALL read data RAM combinationally at word (rs1+imm)[log2(DMEM_WORDS)+1:2]; SW SHALL write on the rising edge; low two address bits ignored.
REQ-024 Load ports SHALL write on the rising edge where their strobe is 1, at word addr[..:2] (regfile: index), independent of rst_n.
REQ-025 When a load-port write and a core write target the same storage in the same cycle, the load-port write SHALL win.
REQ-026 Strobes at X/0 SHALL cause no write.

Reset
REQ-027 rst_n low SHALL asynchronously force pc to 0x00000000 and hold it there; no instruction retires while rst_n is low.
REQ-028 Reset SHALL NOT clear instruction RAM, data RAM or register file; contents survive any number of resets.
REQ-029 The first instruction after rst_n deasserts SHALL be the one at address 0, retired on the first rising edge with rst_n high.

Structure
REQ-030 Package nx_riscv_pkg SHALL hold opcode/funct3/funct7 constants and the ALU-operation enum.
REQ-031 One sub-module nx_riscv_alu (two 32-bit operands, ALU op, 32-bit result, zero flag) SHALL be used; memories, regfile, decode and pc logic live in the top.

Verification
REQ-032 Load 0x001101B3 (add x3,x2,x1) at byte addr 0x08, x1=38, x2=22, pulse reset -> after third edge post-reset x3=60, pc=0x0C, x1/x2 unchanged.
REQ-033 Words 0x00 and 0x04 left 0 -> pc steps 0,4,8 with no register change.
REQ-034 Load x1=5, then addi x1,x0,7 while regfile_wen_initial writes x1=9 same edge -> x1=9; load-port write to x0 -> x0 reads 0.
REQ-035 Data RAM word 0x10 = 0xDEADBEEF via load port; lw x5,16(x0); sw x5,20(x0) -> x5=0xDEADBEEF, data word 0x14=0xDEADBEEF.
REQ-036 x1=x2=3, beq x1,x2,+8 at 0x00 -> pc 0x08; bne same regs -> pc 0x04; jal x1,-4 at 0x08 -> pc 0x04, x1=0x0C.
REQ-037 Assert rst_n low mid-program -> pc=0 immediately (before next edge), regfile contents retained.
